mem8x8_ctrl: RTL and testbench

Access controller for the 8x8 SRAM array built from bitcells. Two requester ports share the single array through a round-robin arbiter. A state machine sequences each access into setup, strobe and hold phases, driving one-hot per-row write/read enables and their complements. This guarantees the cell rule that write-enable and read-enable are never active together.

---
 rtl/mem8x8_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem8x8_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem8x8_ctrl.sv
// Access controller for the 8x8 bitcell SRAM: round-robin arbitration of two ports and phased write/read strobes.
// Optional write-verify read-back is compiled in with `define MEM8X8_CTRL_VERIFY_EN.
module mem8x8_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic                   req0_we,
  input  logic [ADDR_W-1:0]      req0_addr,
  input  logic [DATA_W-1:0]      req0_wdata,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic                   req1_we,
  input  logic [ADDR_W-1:0]      req1_addr,
  input  logic [DATA_W-1:0]      req1_wdata,
  output logic                   req1_ready,
  output logic                   rsp0_valid,
  output logic [DATA_W-1:0]      rsp0_rdata,
  output logic                   rsp0_err,
  output logic                   rsp1_valid,
  output logic [DATA_W-1:0]      rsp1_rdata,
  output logic                   rsp1_err,
  output logic [(1<<ADDR_W)-1:0] mem_we,
  output logic [(1<<ADDR_W)-1:0] mem_wen,
  output logic [(1<<ADDR_W)-1:0] mem_re,
  output logic [(1<<ADDR_W)-1:0] mem_ren,
  output logic [DATA_W-1:0]      mem_din,
  input  logic [DATA_W-1:0]      mem_dout
);

  localparam int ROWS = 1 << ADDR_W;

  typedef enum logic [3:0] {
    IDLE, WR_SETUP, WR_PULSE, WR_HOLD,
`ifdef MEM8X8_CTRL_VERIFY_EN
    VF_EN, VF_CAP,
`endif
    RD_EN, RD_CAP, DONE
  } state_t;

  state_t              state;
  logic                prio;      // 1: port 1 wins the next tie
  logic                lat_port;
  logic [ADDR_W-1:0]   lat_addr;
  logic                grant0, grant1;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                finish;
  logic [DATA_W-1:0]   fin_rdata;
  logic                fin_err;

  function automatic logic [ROWS-1:0] row_sel(input logic [ADDR_W-1:0] a);
    logic [ROWS-1:0] r;
    r    = '0;
    r[a] = 1'b1;
    return r;
  endfunction

  always_comb begin
    grant0    = req0_valid && (!req1_valid || !prio);
    grant1    = req1_valid && (!req0_valid ||  prio);
    sel_we    = grant1 ? req1_we    : req0_we;
    sel_addr  = grant1 ? req1_addr  : req0_addr;
    sel_wdata = grant1 ? req1_wdata : req0_wdata;
  end

  assign req0_ready = (state == IDLE) && !rst && grant0;
  assign req1_ready = (state == IDLE) && !rst && grant1;
  assign mem_wen    = ~mem_we;
  assign mem_ren    = ~mem_re;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    finish    = 1'b0;
    fin_rdata = '0;
    fin_err   = 1'b0;
    case (state)
      RD_CAP: begin
        finish    = 1'b1;
        fin_rdata = mem_dout;
      end
`ifdef MEM8X8_CTRL_VERIFY_EN
      VF_CAP: begin
        finish    = 1'b1;
        fin_rdata = mem_dout;
        fin_err   = (mem_dout != mem_din);   // mem_din still holds the written word
      end
`else
      WR_HOLD: finish = 1'b1;
`endif
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      lat_port   <= 1'b0;
      lat_addr   <= '0;
      mem_we     <= '0;
      mem_re     <= '0;
      mem_din    <= '0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            lat_port <= grant1;
            lat_addr <= sel_addr;
            prio     <= grant0;
            if (sel_we) begin
              mem_din <= sel_wdata;
              state   <= WR_SETUP;
            end else begin
              mem_re  <= row_sel(sel_addr);
              state   <= RD_EN;
            end
          end
        end
        WR_SETUP: begin
          mem_we <= row_sel(lat_addr);
          state  <= WR_PULSE;
        end
        WR_PULSE: begin
          mem_we <= '0;
          state  <= WR_HOLD;
        end
`ifdef MEM8X8_CTRL_VERIFY_EN
        WR_HOLD: begin
          mem_re <= row_sel(lat_addr);
          state  <= VF_EN;
        end
        VF_EN:  state <= VF_CAP;
        VF_CAP: begin
          mem_re <= '0;
          state  <= DONE;
        end
`else
        WR_HOLD: state <= DONE;
`endif
        RD_EN:  state <= RD_CAP;
        RD_CAP: begin
          mem_re <= '0;
          state  <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (finish) begin
        if (lat_port) begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= fin_rdata;
          rsp1_err   <= fin_err;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= fin_rdata;
          rsp0_err   <= fin_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem8x8_ctrl.sv
// Self-checking bench for mem8x8_ctrl: behavioural array, table-driven accesses, scoreboard of responses.
// Build with MEM8X8_CTRL_VERIFY_EN defined to exercise the write-verify path with a stuck-at cell.
module tb_mem8x8_ctrl;

`ifdef MEM8X8_CTRL_VERIFY_EN
  localparam bit VF     = 1'b1;
  localparam int LAT_WR = 6;
`else
  localparam bit VF     = 1'b0;
  localparam int LAT_WR = 4;
`endif
  localparam int LAT_RD = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_we, req1_valid, req1_we;
  logic [2:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [7:0] mem_we, mem_wen, mem_re, mem_ren, mem_din, mem_dout;

  mem8x8_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_we(mem_we), .mem_wen(mem_wen), .mem_re(mem_re), .mem_ren(mem_ren),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Behavioural bitcell array; the verify build models row 6 bit 0 stuck at 0.
  logic [7:0] arr [8];
  always @(posedge clk) begin
    for (int r = 0; r < 8; r++)
      if (mem_we[r]) begin
        arr[r] <= mem_din;
`ifdef MEM8X8_CTRL_VERIFY_EN
        if (r == 6) arr[r] <= mem_din & 8'hFE;
`endif
      end
  end
  always_comb begin
    mem_dout = '0;
    for (int r = 0; r < 8; r++)
      if (mem_re[r]) mem_dout = mem_dout | arr[r];
  end

  typedef struct {
    int         port;
    logic [7:0] rdata;
    bit         err;
    int         due;
  } exp_t;

  typedef struct {
    int         port;
    bit         we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   we08 = 0;
  int   re08 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int port, input logic [7:0] rd, input bit err, input int lat);
    exp_t e;
    e.port  = port;
    e.rdata = rd;
    e.err   = err;
    e.due   = cyc + lat;
    q.push_back(e);
  endtask

  // Monitor: invariants every cycle, responses popped against the scoreboard.
  always @(negedge clk) begin
    bit ok;
    exp_t e;
    ok = !((|mem_we) && (|mem_re)) && $onehot0(mem_we) && $onehot0(mem_re) &&
         (mem_wen == ~mem_we) && (mem_ren == ~mem_re) && !(req0_ready && req1_ready) &&
         (!req0_ready || req0_valid) && (!req1_ready || req1_valid);
    check("invariant", ok, 1);
    if (mem_we == 8'h08) we08++;
    if (mem_re == 8'h08) re08++;
    if (rsp0_valid || rsp1_valid) begin
      check("rsp_both_ports", rsp0_valid & rsp1_valid, 0);
      if (q.size() == 0) begin
        check("rsp_spurious", {rsp1_valid, rsp0_valid}, 0);
      end else begin
        e = q.pop_front();
        check("rsp_port",    rsp1_valid, e.port);
        check("rsp_rdata",   rsp1_valid ? rsp1_rdata : rsp0_rdata, e.rdata);
        check("rsp_err",     rsp1_valid ? rsp1_err : rsp0_err, e.err);
        check("rsp_latency", cyc, e.due);
      end
    end
  end

  task automatic issue(input int port, input bit we, input logic [2:0] addr, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input bit exp_err, output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    @(posedge clk); #1;
    if (port == 0) begin
      req0_we = we; req0_addr = addr; req0_wdata = wd; req0_valid = 1'b1;
    end else begin
      req1_we = we; req1_addr = addr; req1_wdata = wd; req1_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) begin
        push(port, exp_rd, exp_err, we ? LAT_WR : LAT_RD);
        got = 1'b1;
        break;
      end
      waited++;
    end
    check("accept", got, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    check("drain", q.size(), 0);
  endtask

  vec_t tbl [11];
  int   w;
  int   ng;
  int   glog [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{0, 1'b1, 3'd0, 8'h11, 8'h00},
      '{1, 1'b1, 3'd2, 8'h22, 8'h00},
      '{1, 1'b1, 3'd4, 8'hC3, 8'h00},
      '{0, 1'b1, 3'd7, 8'hFF, 8'h00},
      '{1, 1'b0, 3'd0, 8'h00, 8'h11},
      '{0, 1'b0, 3'd2, 8'h00, 8'h22},
      '{1, 1'b0, 3'd7, 8'h00, 8'hFF},
      '{0, 1'b1, 3'd0, 8'h00, 8'h00},
      '{0, 1'b0, 3'd0, 8'h00, 8'h00},
      '{1, 1'b0, 3'd4, 8'h00, 8'hC3},
      '{0, 1'b0, 3'd3, 8'h00, 8'hA5}
    };
    rst = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;

    // Reset state, then quiet idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wen", mem_wen, 8'hFF);
    check("rst_ren", mem_ren, 8'hFF);
    check("rst_we_re", {mem_we, mem_re}, 16'h0);
    check("rst_din", mem_din, 8'h00);
    check("rst_rsp", {rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", {req0_ready, req1_ready}, 2'b00);
      check("idle_strobes", {mem_we, mem_re}, 16'h0);
    end

    // Port 0 writes A5 to row 3, then reads it back.
    we08 = 0; re08 = 0;
    issue(0, 1'b1, 3'd3, 8'hA5, VF ? 8'hA5 : 8'h00, 1'b0, w);
    drain();
    check("wr_we_cycles", we08, 1);
    check("wr_re_cycles", re08, VF ? 2 : 0);
    we08 = 0; re08 = 0;
    issue(0, 1'b0, 3'd3, 8'h00, 8'hA5, 1'b0, w);
    drain();
    check("rd_re_cycles", re08, 2);
    check("rd_we_cycles", we08, 0);

    // Table of back-to-back single-port accesses.
    for (int i = 0; i < 11; i++)
      issue(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata,
            tbl[i].we ? (VF ? tbl[i].wdata : 8'h00) : tbl[i].rdata, 1'b0, w);
    drain();

    // Reset during WR_PULSE of a write to row 5.
    @(posedge clk); #1;
    req0_we = 1'b1; req0_addr = 3'd5; req0_wdata = 8'h5A; req0_valid = 1'b1;
    @(negedge clk);
    check("abort_ready", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    check("abort_setup_din", {mem_we, mem_din}, {8'h00, 8'h5A});
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_pulse_we", mem_we, 8'h20);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_we", mem_we, 8'h00);
    check("abort_wen", mem_wen, 8'hFF);
    check("abort_re", mem_re, 8'h00);
    issue(0, 1'b0, 3'd2, 8'h00, 8'h22, 1'b0, w);
    check("abort_idle_accept", w, 0);
    drain();
    repeat (6) @(posedge clk);

    // Both ports valid continuously after reset: grants alternate starting with port 0.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req0_we = 1'b1; req0_addr = 3'd1; req0_wdata = 8'h3C; req0_valid = 1'b1;
    req1_we = 1'b0; req1_addr = 3'd4; req1_wdata = 8'h00; req1_valid = 1'b1;
    ng = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      @(negedge clk);
      if (req0_ready) begin
        push(0, VF ? 8'h3C : 8'h00, 1'b0, LAT_WR);
        glog[ng] = 0;
        ng++;
      end else if (req1_ready) begin
        push(1, 8'hC3, 1'b0, LAT_RD);
        glog[ng] = 1;
        ng++;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("arb_grants", ng, 4);
    for (int k = 0; k < ng; k++) check("arb_order", glog[k], k % 2);
    drain();

`ifdef MEM8X8_CTRL_VERIFY_EN
    // Write-verify against the stuck-at-0 cell in row 6 bit 0.
    issue(1, 1'b1, 3'd6, 8'h01, 8'h00, 1'b1, w);
    issue(1, 1'b1, 3'd6, 8'h80, 8'h80, 1'b0, w);
    drain();
`endif

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
